// File: rtl/lsu_pkg.sv
// Shared encodings and helpers for the load/store unit.
package lsu_pkg;

    localparam int LANES     = 4;
    localparam int WORD_BITS = LANES * 8;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    typedef enum logic [2:0] {
        IDLE,
        READ,
        WAIT,
        WRITE,
        RESP
    } lsu_state_t;

    // Size 11 is illegal; halves need an even address, words a lane-0 address.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lane);
        logic bad;
        case (size)
            SIZE_BYTE: bad = 1'b0;
            SIZE_HALF: bad = lane[0];
            SIZE_WORD: bad = (lane != 2'b00);
            default:   bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Lane extract with sign/zero extension for loads, lane merge for sub-word stores.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [1:0]           size,
    input  logic                 is_unsigned,
    input  logic [1:0]           lane,
    input  logic [WORD_BITS-1:0] rd_word,
    input  logic [WORD_BITS-1:0] wdata,
    output logic [WORD_BITS-1:0] load_data,
    output logic [WORD_BITS-1:0] merged
);

    logic [WORD_BITS-1:0] shifted;

    // Right-justify the addressed lane(s), then extend or splice as the size dictates.
    always_comb begin
        shifted   = rd_word >> {lane, 3'b000};
        load_data = rd_word;
        merged    = rd_word;
        case (size)
            SIZE_BYTE: begin
                load_data = {{24{~is_unsigned & shifted[7]}}, shifted[7:0]};
                merged[{lane, 3'b000} +: 8] = wdata[7:0];
            end
            SIZE_HALF: begin
                load_data = {{16{~is_unsigned & shifted[15]}}, shifted[15:0]};
                merged[{lane[1], 4'b0000} +: 16] = wdata[15:0];
            end
            default: begin
                load_data = rd_word;
                merged    = wdata;
            end
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Initiator-side load/store controller driving a one-cycle-latency synchronous data memory.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [1:0]            req_size,
    input  logic                  req_unsigned,
    input  logic [ADDR_WIDTH+1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  resp_valid,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic                  resp_error,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [DATA_WIDTH-1:0] mem_write_data,
    output logic                  mem_read,
    output logic                  mem_write,
    input  logic [DATA_WIDTH-1:0] mem_read_data
);

    lsu_state_t            state;
    logic                  op_write;
    logic [1:0]            op_size;
    logic                  op_unsigned;
    logic [1:0]            op_lane;
    logic [DATA_WIDTH-1:0] op_wdata;
    logic                  mem_read_q;
    logic                  mem_write_q;
    logic [DATA_WIDTH-1:0] load_data;
    logic [DATA_WIDTH-1:0] merged;

    lsu_align u_align (
        .size        (op_size),
        .is_unsigned (op_unsigned),
        .lane        (op_lane),
        .rd_word     (mem_read_data),
        .wdata       (op_wdata),
        .load_data   (load_data),
        .merged      (merged)
    );

    // Strobes are masked by reset so an aborted access can never commit.
    assign mem_read  = mem_read_q & ~reset;
    assign mem_write = mem_write_q & ~reset;

    // Control FSM; every output is registered on the transition into the state that owns it.
    always_ff @(posedge clock) begin
        if (reset) begin
            state          <= IDLE;
            req_ready      <= 1'b1;
            resp_valid     <= 1'b0;
            resp_error     <= 1'b0;
            resp_rdata     <= '0;
            mem_read_q     <= 1'b0;
            mem_write_q    <= 1'b0;
            mem_write_data <= '0;
            mem_address    <= '0;
            op_write       <= 1'b0;
            op_size        <= SIZE_BYTE;
            op_unsigned    <= 1'b0;
            op_lane        <= 2'b00;
            op_wdata       <= '0;
        end else begin
            resp_valid  <= 1'b0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        op_write    <= req_write;
                        op_size     <= req_size;
                        op_unsigned <= req_unsigned;
                        op_lane     <= req_addr[1:0];
                        op_wdata    <= req_wdata;
                        mem_address <= req_addr[ADDR_WIDTH+1:2];
                        req_ready   <= 1'b0;
                        resp_rdata  <= '0;
                        resp_error  <= 1'b0;
                        if (is_misaligned(req_size, req_addr[1:0])) begin
                            resp_valid <= 1'b1;
                            resp_error <= 1'b1;
                            state      <= RESP;
                        end else if (req_write && req_size == SIZE_WORD) begin
                            mem_write_data <= req_wdata;
                            mem_write_q    <= 1'b1;
                            state          <= WRITE;
                        end else begin
                            mem_read_q <= 1'b1;
                            state      <= READ;
                        end
                    end
                end
                READ: state <= WAIT;
                WAIT: begin
                    if (op_write) begin
                        mem_write_data <= merged;
                        mem_write_q    <= 1'b1;
                        state          <= WRITE;
                    end else begin
                        resp_rdata <= load_data;
                        resp_valid <= 1'b1;
                        state      <= RESP;
                    end
                end
                WRITE: begin
                    resp_valid <= 1'b1;
                    state      <= RESP;
                end
                RESP: begin
                    req_ready  <= 1'b1;
                    resp_error <= 1'b0;
                    state      <= IDLE;
                end
                default: begin
                    req_ready <= 1'b1;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Initiator-side memory access controller for the processor datapath; it is the master that drives the synchronous data memory's Address/Write_Data/Mem_Read/Mem_Write port.
- Accepts one byte/halfword/word load or store per handshake from the pipeline, issues the word-addressed memory cycles and honours the memory's one-cycle registered-address read latency.
- Performs sub-word stores as read-modify-write, sign/zero-extends loads, and flags misaligned or illegal requests.

Parameters:
- DATA_WIDTH, 32, memory word width; fixed at 32 (4 byte lanes).
- ADDR_WIDTH, 8, word-address width of the data memory; byte address is ADDR_WIDTH+2 bits.

Ports:
- clock  in  1  system clock, all logic on posedge.
- reset  in  1  synchronous, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  high only in IDLE; transfer when req_valid&&req_ready.
- req_write  in  1  1=store, 0=load.
- req_size  in  2  00 byte, 01 half, 10 word, 11 illegal.
- req_unsigned  in  1  loads: 1 zero-extend, 0 sign-extend.
- req_addr  in  ADDR_WIDTH+2  byte address.
- req_wdata  in  DATA_WIDTH  store data, right-justified.
- resp_valid  out  1  one-cycle completion pulse.
- resp_rdata  out  DATA_WIDTH  extended load data; 0 for stores/errors.
- resp_error  out  1  valid with resp_valid; misaligned or size 11.
- mem_address  out  ADDR_WIDTH  req_addr[ADDR_WIDTH+1:2].
- mem_write_data  out  DATA_WIDTH  full word to write.
- mem_read  out  1  read strobe.
- mem_write  out  1  write strobe.
- mem_read_data  in  DATA_WIDTH  memory data, valid the cycle after mem_address is sampled.

Behaviour:
- The interface uses one clock and a synchronous active-high reset, with ports named clock and reset.
- Reset: state IDLE; req_ready=1 after the first edge with reset high; resp_valid, resp_error, mem_read, mem_write = 0; resp_rdata, mem_write_data, mem_address = 0.
- mem_read and mem_write are gated with !reset, so nothing commits while reset is high. They are never both high.
- Request fields are latched on accept and are ignored otherwise. mem_address is held from accept until RESP.
- Byte lanes are little-endian: lane n = bits [8n+7:8n]. Byte lane = addr[1:0]; half lane = addr[1].
- Misaligned requests: half with addr[0]=1, word with addr[1:0]!=0, or size 11. These go to RESP with resp_error=1 and cause no memory cycle.

States:
- IDLE: req_ready=1. On accept, the next state is RESP (error), WRITE (word store) or READ (load or sub-word store).
- READ: mem_read=1 for one cycle, then WAIT.
- WAIT: sample mem_read_data.
  - Load: extract the lane(s), extend, register into resp_rdata, then RESP.
  - Sub-word store: merge store bytes into the read word, register into mem_write_data, then WRITE.
- WRITE: mem_write=1 for exactly one cycle. mem_write_data = req_wdata (word) or the merged word. Then RESP.
- RESP: resp_valid=1 for one cycle, then IDLE. There is no response backpressure.

Latency (accept cycle T):
- Error: resp_valid at T+1.
- Word store: mem_write at T+1, resp at T+2.
- Load: mem_read at T+1, resp at T+3.
- Sub-word store: mem_read at T+1, mem_write at T+3, resp at T+4.

Other rules:
- Throughput: the next accept is possible no earlier than the cycle after RESP.
- Reset in any state aborts the access: no write commits and no resp_valid is produced. The unit is in IDLE the cycle after reset deasserts.

Decomposition:
- Shared package (lsu_pkg): size encodings SIZE_BYTE/SIZE_HALF/SIZE_WORD, state enum IDLE/READ/WAIT/WRITE/RESP, and a lane-count constant.
- One natural sub-module: lsu_align, purely combinational. It performs lane extract plus sign/zero extend for loads and lane merge for stores. The FSM stays in the top module.

Test Plan:
- Store word 0xDEADBEEF at req_addr 0x010, then load word at 0x010. Required: mem_write for one cycle with mem_address 0x04, and resp_rdata=0xDEADBEEF at T+3.
- Preload word 5 = 0x80FF7F01. Required:
  - Signed byte load at 0x017 gives 0xFFFFFF80.
  - Unsigned byte load at 0x017 gives 0x00000080.
  - Signed half load at 0x014 gives 0x00007F01.
- Word 5 = 0x11223344; store byte 0xAA at 0x015. Required: mem_read at T+1, mem_write at T+3 with data 0x1122AA44, resp_valid at T+4, and a subsequent word load returns 0x1122AA44.
- Half load at 0x013 and a size=11 request. Required: resp_error=1 and resp_rdata=0 at T+1, with mem_read and mem_write never asserted.
- Byte store 0xAA at 0x015, reset asserted during WAIT. Required: no mem_write and no resp_valid, word 5 unchanged, req_ready=1 after reset releases.
- req_valid held high with two queued requests. Required: req_ready low from T+1 through RESP, and the second request is accepted only in the IDLE cycle after RESP.
